// File: rtl/ib_vnu_lut_loader.sv
// IB-VNU LUT loader: takes a stream of iteration-update LUT entry pairs from
// an upstream source and writes them into both replicates of the LUT RAM.
// One load writes every page of one multi-frame half, in page order.
module ib_vnu_lut_loader #(
    parameter int QUAN_SIZE     = 3,
    parameter int ENTRY_ADDR    = 2*QUAN_SIZE-1,
    parameter int LUT_PORT_SIZE = 3,
    parameter int BANK_NUM      = 1,
    parameter int ITER_WIDTH    = 4
) (
    input  logic                              write_clk,
    input  logic                              rstn,
    input  logic                              load_start,
    input  logic                              load_frame,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] in_data_0,
    input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] in_data_1,
    output logic [ENTRY_ADDR-1:0]             page_addr_ram_replicate_0,
    output logic [ENTRY_ADDR-1:0]             page_addr_ram_replicate_1,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_0,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
    output logic                              ib_ram_we,
    output logic                              load_busy,
    output logic                              load_done,
    output logic [ITER_WIDTH-1:0]             iter_cnt
);

    localparam int PG_W = ENTRY_ADDR - 1;
    localparam int DW   = LUT_PORT_SIZE * BANK_NUM;

    localparam logic [PG_W-1:0]       PG_LAST  = '1;
    localparam logic [PG_W-1:0]       PG_ONE   = PG_W'(1);
    localparam logic [ITER_WIDTH-1:0] ITER_ONE = ITER_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  fr;
    logic [PG_W-1:0]       pg;
    logic                  accept;
    logic                  last_accept;
    logic [ITER_WIDTH-1:0] iter_q;

    logic                  vld_p1;
    logic [ENTRY_ADDR-1:0] addr_p1;
    logic [DW-1:0]         data_0_p1;
    logic [DW-1:0]         data_1_p1;

    assign accept      = in_valid & in_ready;
    assign last_accept = accept && (pg == PG_LAST);

    // State register; reset drops straight back to IDLE
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded handshake/status outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load_busy = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready  = 1'b1;
                load_busy = 1'b1;
                if (in_valid && (pg == PG_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // This cycle also carries the write of the final page.
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame latch, page counter and completed-load counter
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            fr     <= 1'b0;
            pg     <= '0;
            iter_q <= '0;
        end else begin
            if ((state == IDLE) && load_start) begin
                fr <= load_frame;
                pg <= '0;
            end else if (accept) begin
                // Natural wrap returns pg to 0 after the last page.
                pg <= pg + PG_ONE;
            end
            if (last_accept) begin
                iter_q <= iter_q + ITER_ONE;
            end
        end
    end

    // ---- stage p1: write presented one cycle after the accept ----
    // Address and data only move on an accept so they hold between writes
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            data_0_p1 <= '0;
            data_1_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                addr_p1   <= {fr, pg};
                data_0_p1 <= in_data_0;
                data_1_p1 <= in_data_1;
            end
        end
    end

    assign ib_ram_we                 = vld_p1;
    assign page_addr_ram_replicate_0 = addr_p1;
    assign page_addr_ram_replicate_1 = addr_p1;
    assign ram_write_data_0          = data_0_p1;
    assign ram_write_data_1          = data_1_p1;
    assign iter_cnt                  = iter_q;

endmodule

// File: tb/tb_ib_vnu_lut_loader.sv
// Bench for ib_vnu_lut_loader: a table of fixed vectors for two full loads,
// hand-written corner sequences, and randomized loads against a page-count
// reference model.
module tb_ib_vnu_lut_loader;

    localparam int PAGES = 16;

    logic       clk;
    logic       rstn;
    logic       load_start;
    logic       load_frame;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data_0;
    logic [2:0] in_data_1;
    logic [4:0] addr_0;
    logic [4:0] addr_1;
    logic [2:0] wdata_0;
    logic [2:0] wdata_1;
    logic       ib_ram_we;
    logic       load_busy;
    logic       load_done;
    logic [3:0] iter_cnt;

    ib_vnu_lut_loader dut (
        .write_clk                 (clk),
        .rstn                      (rstn),
        .load_start                (load_start),
        .load_frame                (load_frame),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_data_0                 (in_data_0),
        .in_data_1                 (in_data_1),
        .page_addr_ram_replicate_0 (addr_0),
        .page_addr_ram_replicate_1 (addr_1),
        .ram_write_data_0          (wdata_0),
        .ram_write_data_1          (wdata_1),
        .ib_ram_we                 (ib_ram_we),
        .load_busy                 (load_busy),
        .load_done                 (load_done),
        .iter_cnt                  (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n_we        = 0;

    // Reference model: phase 0 = waiting for a start, 1 = collecting pages,
    // 2 = the single completion cycle. Writes are computed from the count of
    // pages taken so far.
    int         m_phase;
    int         m_frame;
    int         m_count;
    int         m_iter;
    logic       m_we;
    logic       m_done;
    logic [4:0] m_addr;
    logic [2:0] m_d0;
    logic [2:0] m_d1;

    typedef struct {
        logic       start;
        logic       frame;
        logic       valid;
        logic [2:0] d0;
        logic [2:0] d1;
        logic       exp_we;
        logic [4:0] exp_addr;
        logic [2:0] exp_d0;
        logic [2:0] exp_d1;
        logic       exp_done;
        logic [3:0] exp_iter;
    } vec_t;

    vec_t tbl[36];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_frame = 0; m_count = 0; m_iter = 0;
        m_we = 1'b0; m_done = 1'b0; m_addr = '0; m_d0 = '0; m_d1 = '0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic v,
                              input logic [2:0] a, input logic [2:0] b);
        m_we   = 1'b0;
        m_done = 1'b0;
        case (m_phase)
            0: if (s) begin
                m_frame = int'(f);
                m_count = 0;
                m_phase = 1;
            end
            1: if (v) begin
                m_we   = 1'b1;
                m_addr = 5'(m_frame * PAGES + m_count);
                m_d0   = a;
                m_d1   = b;
                m_count++;
                if (m_count == PAGES) begin
                    m_phase = 2;
                    m_done  = 1'b1;
                    m_iter  = (m_iter + 1) % 16;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("we",     32'(ib_ram_we), 32'(m_we));
        chk("addr_0", 32'(addr_0),    32'(m_addr));
        chk("addr_1", 32'(addr_1),    32'(m_addr));
        chk("data_0", 32'(wdata_0),   32'(m_d0));
        chk("data_1", 32'(wdata_1),   32'(m_d1));
        chk("ready",  32'(in_ready),  32'(m_phase == 1));
        chk("busy",   32'(load_busy), 32'(m_phase == 1));
        chk("done",   32'(load_done), 32'(m_done));
        chk("iter",   32'(iter_cnt),  32'(m_iter));
    endtask

    // One clock: drive inputs just after a falling edge, let the rising edge
    // act, then compare everything at the next falling edge.
    task automatic cycle(input logic s, input logic f, input logic v,
                         input logic [2:0] a, input logic [2:0] b);
        load_start = s;
        load_frame = f;
        in_valid   = v;
        in_data_0  = a;
        in_data_1  = b;
        model_step(s, f, v, a, b);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (ib_ram_we) n_we++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"},    32'(ib_ram_we), 0);
        chk({tag, "_addr0"}, 32'(addr_0),    0);
        chk({tag, "_addr1"}, 32'(addr_1),    0);
        chk({tag, "_data0"}, 32'(wdata_0),   0);
        chk({tag, "_data1"}, 32'(wdata_1),   0);
        chk({tag, "_ready"}, 32'(in_ready),  0);
        chk({tag, "_busy"},  32'(load_busy), 0);
        chk({tag, "_done"},  32'(load_done), 0);
        chk({tag, "_iter"},  32'(iter_cnt),  0);
    endtask

    // mode 0: in_valid always high; 1: pattern 1,0,0 repeating;
    // 2: random in_valid, random ignored start pulses.
    // inj re-pulses load_start with the frame flipped on the page-5 accept.
    task automatic run_load(input logic f, input int mode, input bit inj);
        bit   got;
        bit   ign_checked;
        logic v;
        logic s;
        logic ff;
        cycle(1'b1, f, 1'b0, 3'd0, 3'd0);
        n_we        = 0;
        got         = 1'b0;
        ign_checked = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((c % 3) == 0);
                default: v = (($urandom % 4) != 0);
            endcase
            s  = 1'b0;
            ff = f;
            if (mode == 2) begin
                s  = (($urandom % 6) == 0);
                ff = 1'($urandom);
            end
            if (inj && (n_we == 5) && v) begin
                s  = 1'b1;
                ff = ~f;
            end
            cycle(s, ff, v, 3'($urandom), 3'($urandom));
            if (inj && !ign_checked && (n_we == 7)) begin
                chk("ign_start_page6_addr", 32'(addr_0), 32'({f, 4'd6}));
                ign_checked = 1'b1;
            end
            if (load_done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            miscompares++;
            $display("FAIL load_timeout: got no load_done, want one within 400 cycles");
        end
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    initial begin
        int p;
        int base;

        // Two back-to-back loads (frame 0 then frame 1) from reset.
        for (int fi = 0; fi < 2; fi++) begin
            base = fi * 18;
            tbl[base] = '{start: 1'b1, frame: 1'(fi), valid: 1'b0, d0: 3'd0, d1: 3'd0,
                          exp_we: 1'b0, exp_addr: (fi == 0) ? 5'd0 : 5'd15,
                          exp_d0: (fi == 0) ? 3'd0 : 3'd7, exp_d1: 3'd0,
                          exp_done: 1'b0, exp_iter: 4'(fi)};
            for (int k = 1; k <= 16; k++) begin
                p = k - 1;
                tbl[base + k] = '{start: 1'b0, frame: 1'(fi), valid: 1'b1,
                                  d0: 3'(p % 8), d1: 3'(7 - (p % 8)),
                                  exp_we: 1'b1, exp_addr: 5'(fi * 16 + p),
                                  exp_d0: 3'(p % 8), exp_d1: 3'(7 - (p % 8)),
                                  exp_done: (p == 15), exp_iter: 4'(fi + ((p == 15) ? 1 : 0))};
            end
            tbl[base + 17] = '{start: 1'b0, frame: 1'b0, valid: 1'b0, d0: 3'd0, d1: 3'd0,
                               exp_we: 1'b0, exp_addr: 5'(fi * 16 + 15),
                               exp_d0: 3'd7, exp_d1: 3'd0,
                               exp_done: 1'b0, exp_iter: 4'(fi + 1)};
        end

        rstn       = 1'b0;
        load_start = 1'b0;
        load_frame = 1'b0;
        in_valid   = 1'b0;
        in_data_0  = '0;
        in_data_1  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 36; i++) begin
            cycle(tbl[i].start, tbl[i].frame, tbl[i].valid, tbl[i].d0, tbl[i].d1);
            chk("tbl_we",   32'(ib_ram_we), 32'(tbl[i].exp_we));
            chk("tbl_addr", 32'(addr_1),    32'(tbl[i].exp_addr));
            chk("tbl_d0",   32'(wdata_0),   32'(tbl[i].exp_d0));
            chk("tbl_d1",   32'(wdata_1),   32'(tbl[i].exp_d1));
            chk("tbl_done", 32'(load_done), 32'(tbl[i].exp_done));
            chk("tbl_iter", 32'(iter_cnt),  32'(tbl[i].exp_iter));
        end

        // Backpressure gaps: exactly one write per accept.
        run_load(1'b0, 1, 1'b0);
        chk("bp_write_count", 32'(n_we), 32'(PAGES));

        // Ignored start mid-load.
        run_load(1'b0, 0, 1'b1);
        chk("ign_write_count", 32'(n_we), 32'(PAGES));

        // Reset mid-load after page 8 has been written.
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 1'b1, 3'($urandom), 3'($urandom));
        chk("pre_reset_addr", 32'(addr_0), 32'(5'd24));
        #2 rstn = 1'b0;
        #1 check_all_zero("mid_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        run_load(1'b0, 0, 1'b0);
        chk("restart_write_count", 32'(n_we), 32'(PAGES));

        // Counter wrap over 16 randomized loads from a clean count.
        rstn = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int l = 0; l < 16; l++) begin
            run_load(1'($urandom), 2, 1'b0);
            if (l == 14) chk("iter_before_wrap", 32'(iter_cnt), 32'd15);
        end
        chk("iter_wrap", 32'(iter_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
